// File: rtl/prioritized_stream_arbiter.sv
// Fixed-priority valid/ready stream arbiter with packet lock and a registered single-entry output slot.
// Define STARVATION_GUARD_EN to add per-input wait counters that force a long-waiting input to win in IDLE.
module prioritized_stream_arbiter #(
    parameter int data_width       = 8,
    parameter int number_of_inputs = 4,
    parameter int priority_list [number_of_inputs-1:0] = '{3, 1, 2, 0},
    parameter int starvation_limit = 15
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [data_width-1:0]               in_data  [number_of_inputs],
    input  logic                                in_last  [number_of_inputs],
    input  logic                                in_valid [number_of_inputs],
    output logic                                in_ready [number_of_inputs],
    output logic [data_width-1:0]               out_data,
    output logic                                out_last,
    output logic [$clog2(number_of_inputs)-1:0] out_source,
    output logic                                out_valid,
    input  logic                                out_ready
);
    localparam int SW = $clog2(number_of_inputs);

    generate
        if (number_of_inputs < 2 || starvation_limit < 1) begin : g_bad_params
            $error("prioritized_stream_arbiter: illegal parameters");
        end
    endgenerate

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                      state;
    logic [SW-1:0]               lock_idx;
    logic [SW-1:0]               arb_idx;
    logic [SW-1:0]               grant;
    logic [number_of_inputs-1:0] vld;
    logic [number_of_inputs-1:0] rdy;
    logic [number_of_inputs-1:0] starved;
    logic                        slot_free;
    logic                        accept;

`ifdef STARVATION_GUARD_EN
    localparam int CW = $clog2(starvation_limit + 1);
    logic [CW-1:0] wait_cnt [number_of_inputs];

    always_ff @(posedge clock) begin
        for (int i = 0; i < number_of_inputs; i++) begin
            if (reset || !in_valid[i] || (accept && grant == SW'(i)))
                wait_cnt[i] <= '0;
            else if (wait_cnt[i] != CW'(starvation_limit))
                wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end
    end

    always_comb begin
        starved = '0;
        for (int i = 0; i < number_of_inputs; i++)
            starved[i] = (wait_cnt[i] == CW'(starvation_limit));
    end
`else
    assign starved = '0;
`endif

    // Sort key: starved inputs occupy ranks below every non-starved one.
    always_comb begin
        int best;
        int key;
        arb_idx = '0;
        best    = 2 * number_of_inputs;
        key     = 0;
        for (int i = 0; i < number_of_inputs; i++) begin
            vld[i] = in_valid[i];
            key    = priority_list[i] + (starved[i] ? 0 : number_of_inputs);
            if (in_valid[i] && key < best) begin
                best    = key;
                arb_idx = SW'(i);
            end
        end
    end

    assign slot_free = !out_valid || out_ready;
    assign grant     = (state == LOCKED) ? lock_idx : arb_idx;

    always_comb begin
        rdy = '0;
        for (int i = 0; i < number_of_inputs; i++) begin
            rdy[i]      = !reset && slot_free && (grant == SW'(i)) && (state == LOCKED || |vld);
            in_ready[i] = rdy[i];
        end
    end

    assign accept = |(rdy & vld);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            lock_idx   <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_source <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_data   <= in_data[grant];
            out_last   <= in_last[grant];
            out_source <= grant;
            if (state == IDLE && !in_last[grant]) begin
                state    <= LOCKED;
                lock_idx <= grant;
            end else if (state == LOCKED && in_last[grant]) begin
                state <= IDLE;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
